// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control FSM.
// Used by mc_alu_decode and multicycle_controller.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWR  = 4'd4,
        MEMWB  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_ALU = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] MUL_PAT = 4'b1001;

endpackage

// File: rtl/mc_alu_decode.sv
// Data-processing decoder: Funct/Mul -> ALU op, flag writes, NoWrite.
// Undefined commands decode to ADD with no flag write and raise undef.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [3:0] mul,
    output logic [2:0] alucontrol,
    output logic [1:0] flagw,
    output logic       nowrite,
    output logic       undef,
    output logic       is_mul
);

    logic [3:0] cmd;
    logic       s;
    logic       arith;

    assign cmd = funct[4:1];
    assign s   = funct[0];

    // Map the command field onto an ALU operation and its side effects.
    always_comb begin
        alucontrol = ALU_ADD;
        nowrite    = 1'b0;
        undef      = 1'b0;
        is_mul     = 1'b0;
        arith      = 1'b0;
        case (cmd)
            CMD_ADD: begin
                alucontrol = ALU_ADD;
                arith      = 1'b1;
            end
            CMD_SUB: begin
                alucontrol = ALU_SUB;
                arith      = 1'b1;
            end
            CMD_AND: begin
                if (!funct[5] && mul == MUL_PAT) begin
                    alucontrol = ALU_MUL;
                    is_mul     = 1'b1;
                end else begin
                    alucontrol = ALU_AND;
                end
            end
            CMD_ORR: alucontrol = ALU_ORR;
            CMD_CMP: begin
                alucontrol = ALU_SUB;
                arith      = 1'b1;
                nowrite    = 1'b1;
            end
            CMD_MOV: alucontrol = ALU_MOV;
            default: undef = 1'b1;
        endcase
        flagw = undef ? 2'b00 : {s, s & arith};
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle ARM-subset processor.
// Optional MULTICYCLE_MEM_WAIT_EN: memory states wait for mem_ready.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int MUL_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] Mul,
    input  logic       cond_ex,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemW,
    output logic       RegW,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       BL,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] mul_cnt;
    logic [3:0] mul_cnt_d;
    logic       rdy;
    logic       mul_last;

    logic [2:0] dec_alu;
    logic [1:0] dec_flagw;
    logic       dec_nowrite;
    logic       dec_undef;
    logic       dec_mul;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign rdy = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign rdy = 1'b1;
`endif

    assign state    = state_q;
    assign mul_last = (mul_cnt == 4'(MUL_CYCLES - 1));

    mc_alu_decode u_dec (
        .funct      (Funct),
        .mul        (Mul),
        .alucontrol (dec_alu),
        .flagw      (dec_flagw),
        .nowrite    (dec_nowrite),
        .undef      (dec_undef),
        .is_mul     (dec_mul)
    );

    // State register and multiply cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            mul_cnt <= 4'd0;
        end else begin
            state_q <= state_d;
            mul_cnt <= mul_cnt_d;
        end
    end

    // Next-state logic; the counter only advances while a MUL holds EXECR.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = 4'd0;
        unique case (state_q)
            FETCH:  if (rdy) state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (rdy) state_d = MEMWB;
            MEMWR:  if (rdy) state_d = FETCH;
            MEMWB:  state_d = FETCH;
            EXECR: begin
                if (dec_mul && !mul_last) begin
                    mul_cnt_d = mul_cnt + 4'd1;
                end else begin
                    state_d = dec_nowrite ? FETCH : ALUWB;
                end
            end
            EXECI:  state_d = dec_nowrite ? FETCH : ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode; everything is forced low while reset is high.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemW       = 1'b0;
        RegW       = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ImmSrc     = IMM_ALU;
        RegSrc     = 2'b00;
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        BL         = 1'b0;
        if (!reset) begin
            unique case (state_q)
                FETCH: begin
                    IRWrite   = rdy;
                    PCWrite   = rdy;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                end
                DECODE: begin
                    RegSrc  = 2'b01;
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                end
                MEMADR: begin
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_MEM;
                end
                MEMRD: AdrSrc = 1'b1;
                MEMWR: begin
                    AdrSrc = 1'b1;
                    RegSrc = 2'b10;
                    MemW   = cond_ex & rdy;
                end
                MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegW      = cond_ex;
                end
                EXECR: begin
                    ALUControl = dec_alu;
                    FlagW      = dec_flagw & {2{cond_ex}};
                end
                EXECI: begin
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = dec_alu;
                    FlagW      = dec_flagw & {2{cond_ex}};
                end
                ALUWB: begin
                    RegW    = cond_ex & ~dec_undef;
                    PCWrite = (Rd == 4'd15) & ~dec_undef;
                end
                BRANCH: begin
                    RegSrc    = 2'b01;
                    ALUSrcB   = SRCB_IMM;
                    ImmSrc    = IMM_BR;
                    ResultSrc = RES_ALURES;
                    PCWrite   = cond_ex;
                    BL        = Funct[4] & cond_ex;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// Directed ISA cases, reset cases, then random instructions.
module tb_multicycle_controller;
    import mc_pkg::*;

    localparam int MC = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] Mul;
    logic       cond_ex;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, IRWrite, MemW, RegW, ALUSrcA, BL;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, FlagW;
    logic [2:0] ALUControl;
    logic [3:0] state;

    multicycle_controller #(.MUL_CYCLES(MC)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .Mul        (Mul),
        .cond_ex    (cond_ex),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemW       (MemW),
        .RegW       (RegW),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .BL         (BL),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       irw;
        logic       memw;
        logic       regw;
        logic [1:0] rsrc;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic [2:0] aluc;
        logic [1:0] flagw;
        logic       bl;
    } outs_t;

    typedef struct packed {
        logic [2:0] alu;
        logic       undef;
        logic       arith;
        logic       nowr;
        logic       ismul;
    } dp_t;

    typedef state_t sq_t[$];

    outs_t got;
    assign got = {PCWrite, AdrSrc, IRWrite, MemW, RegW, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl,
                  FlagW, BL};

    int checks = 0;
    int errors = 0;
    int wait_force = -1;
    bit no_wait = 1'b0;

    // Instruction semantics of the data-processing commands.
    function automatic dp_t ref_dp(input logic [5:0] f,
                                   input logic [3:0] m);
        dp_t d;
        d = '0;
        case (f[4:1])
            4'b0100: begin d.alu = 3'b000; d.arith = 1'b1; end
            4'b0010: begin d.alu = 3'b001; d.arith = 1'b1; end
            4'b0000: begin
                if (!f[5] && m == 4'b1001) begin
                    d.alu = 3'b100; d.ismul = 1'b1;
                end else begin
                    d.alu = 3'b010;
                end
            end
            4'b1100: d.alu = 3'b011;
            4'b1010: begin
                d.alu = 3'b001; d.arith = 1'b1; d.nowr = 1'b1;
            end
            4'b1101: d.alu = 3'b101;
            default: d.undef = 1'b1;
        endcase
        return d;
    endfunction

    // The list of phases an instruction walks through, ignoring waits.
    function automatic sq_t phases(input logic [1:0] op,
                                   input logic [5:0] f,
                                   input logic [3:0] m);
        sq_t q;
        dp_t d;
        d = ref_dp(f, m);
        q.push_back(FETCH);
        q.push_back(DECODE);
        case (op)
            2'b00: begin
                for (int k = 0; k < (d.ismul ? MC : 1); k++)
                    q.push_back(f[5] ? EXECI : EXECR);
                if (!d.nowr) q.push_back(ALUWB);
            end
            2'b01: begin
                q.push_back(MEMADR);
                if (f[0]) begin
                    q.push_back(MEMRD);
                    q.push_back(MEMWB);
                end else begin
                    q.push_back(MEMWR);
                end
            end
            2'b10: q.push_back(BRANCH);
            default: ;
        endcase
        return q;
    endfunction

    function automatic bit waitable(input state_t s);
`ifdef MULTICYCLE_MEM_WAIT_EN
        return s == FETCH || s == MEMRD || s == MEMWR;
`else
        return (s != s);
`endif
    endfunction

    // Expected control word for one phase of an instruction.
    function automatic outs_t ref_out(input state_t s,
                                      input logic [5:0] f,
                                      input logic [3:0] rd,
                                      input logic [3:0] m,
                                      input logic c,
                                      input logic r);
        outs_t o;
        dp_t d;
        o = '0;
        d = ref_dp(f, m);
        case (s)
            FETCH: begin
                o.irw = r; o.pcw = r; o.srca = 1'b1;
                o.srcb = 2'b10; o.rsrc = 2'b10;
            end
            DECODE: begin
                o.regsrc = 2'b01; o.srca = 1'b1; o.srcb = 2'b10;
            end
            MEMADR: begin o.srcb = 2'b01; o.imm = 2'b01; end
            MEMRD: o.adr = 1'b1;
            MEMWR: begin
                o.adr = 1'b1; o.regsrc = 2'b10; o.memw = c & r;
            end
            MEMWB: begin o.rsrc = 2'b01; o.regw = c; end
            EXECR, EXECI: begin
                o.aluc = d.alu;
                o.srcb = (s == EXECI) ? 2'b01 : 2'b00;
                if (!d.undef)
                    o.flagw = {f[0] & c, f[0] & d.arith & c};
            end
            ALUWB: begin
                o.regw = c & ~d.undef;
                o.pcw = (rd == 4'd15) & ~d.undef;
            end
            BRANCH: begin
                o.regsrc = 2'b01; o.srcb = 2'b01; o.imm = 2'b10;
                o.rsrc = 2'b10; o.pcw = c; o.bl = f[4] & c;
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic check(input string tag, input state_t es,
                         input outs_t eo);
        checks++;
        assert (state === es) else begin
            errors++;
            $error("FAIL %s state got %0d exp %0d", tag, state, es);
        end
        checks++;
        assert (got === eo) else begin
            errors++;
            $error("FAIL %s outs st %0d got %h exp %h",
                   tag, es, got, eo);
        end
    endtask

    // Called 1ns after a rising edge that starts a FETCH cycle.
    task automatic run_instr(input string tag, input logic [1:0] op,
                             input logic [5:0] f, input logic [3:0] rd,
                             input logic [3:0] m, input logic c,
                             input int abort_at);
        sq_t ph;
        ph = phases(op, f, m);
        Op = op; Funct = f; Rd = rd; Mul = m; cond_ex = c;
        for (int i = 0; i < ph.size(); i++) begin
            int nw;
            nw = 0;
            if (waitable(ph[i]) && !no_wait) begin
                if (wait_force >= 0) begin
                    nw = wait_force;
                    wait_force = -1;
                end else begin
                    nw = $urandom_range(0, 2);
                end
            end
            for (int w = 0; w <= nw; w++) begin
                logic r;
                r = 1'b1;
                if (waitable(ph[i])) begin
                    r = (w == nw);
                    mem_ready = r;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                check(tag, ph[i], ref_out(ph[i], f, rd, m, c, r));
                if (i == abort_at) return;
                @(posedge clk);
                #1;
            end
        end
    endtask

    logic [3:0] cmds [8] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100,
                             4'b1010, 4'b1101, 4'b0001, 4'b1111};

    initial begin
        reset = 1'b1;
        Op = 2'b00; Funct = 6'd0; Rd = 4'd0; Mul = 4'd0;
        cond_ex = 1'b1; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset", FETCH, '0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr("add",    2'b00, 6'b001000, 4'd1,  4'd0, 1'b1, -1);
        run_instr("ldr",    2'b01, 6'b011001, 4'd2,  4'd0, 1'b1, -1);
        run_instr("str",    2'b01, 6'b011000, 4'd2,  4'd0, 1'b1, -1);
        run_instr("mul",    2'b00, 6'b000000, 4'd3,  4'd9, 1'b1, -1);
        run_instr("cmpi",   2'b00, 6'b110101, 4'd0,  4'd0, 1'b1, -1);
        run_instr("bl",     2'b10, 6'b010000, 4'd0,  4'd0, 1'b1, -1);
        run_instr("bl_nc",  2'b10, 6'b010000, 4'd0,  4'd0, 1'b0, -1);
        run_instr("add_pc", 2'b00, 6'b001001, 4'd15, 4'd0, 1'b1, -1);
        run_instr("undef",  2'b00, 6'b000010, 4'd4,  4'd0, 1'b1, -1);
        run_instr("add_nc", 2'b00, 6'b101001, 4'd5,  4'd0, 1'b0, -1);
        run_instr("nop",    2'b11, 6'b000000, 4'd0,  4'd0, 1'b1, -1);

        no_wait = 1'b1;
        run_instr("str_rst", 2'b01, 6'b011000, 4'd6, 4'd0, 1'b1, 3);
        no_wait = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        assert (MemW === 1'b0) else begin
            errors++;
            $error("FAIL rst_memw got %b exp 0", MemW);
        end
        check("rst_async", FETCH, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        run_instr("after_rst", 2'b00, 6'b011010, 4'd7, 4'd0, 1'b1, -1);

`ifdef MULTICYCLE_MEM_WAIT_EN
        wait_force = 2;
        run_instr("fetch_wait", 2'b00, 6'b001000, 4'd1, 4'd0, 1'b1, -1);
`endif

        for (int n = 0; n < 80; n++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic [3:0] rd;
            logic [3:0] m;
            logic       c;
            logic [1:0] hi;
            logic       lo;
            op = 2'($urandom_range(0, 3));
            hi = 2'($urandom_range(0, 3));
            lo = 1'($urandom_range(0, 1));
            f = {hi[1], cmds[$urandom_range(0, 7)], lo};
            if (op != 2'b00) f[4] = hi[0];
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            m = ($urandom_range(0, 1) == 1) ? 4'd9 : 4'($urandom);
            c = ($urandom_range(0, 3) != 0);
            run_instr("rand", op, f, rd, m, c, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
